// File: rtl/simd_hsum_reduce.sv
// Horizontal reduction of one SIMD result vector into a single wide scalar.
// One 64-bit slice is folded into the accumulator per cycle. Valid/ready
// handshakes are used on both the input side and the output side.
module simd_hsum_reduce #(
  parameter int SIMD_DATA_WIDTH = 256,
  parameter int ACC_WIDTH       = 72
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]   in_data,
  input  logic [SIMD_DATA_WIDTH/8-1:0] in_ovf,
  input  logic [SIMD_DATA_WIDTH/8-1:0] in_udf,
  input  logic [1:0]                   in_esize,
  input  logic                         in_signed,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_sum,
  output logic                         out_narrow_ovf,
  output logic                         out_lane_flag
);

  localparam int NSLICE = SIMD_DATA_WIDTH / 64;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                       state;
  logic [SIMD_DATA_WIDTH-1:0]   data_q;
  logic [1:0]                   esize_q;
  logic                         signed_q;
  logic                         lane_flag_q;
  logic [CW-1:0]                cnt;
  logic [ACC_WIDTH-1:0]         acc;
  logic [63:0]                  slice;
  logic [ACC_WIDTH-1:0]         slice_sum;
  logic [ACC_WIDTH-1:0]         acc_next;
  logic                         narrow;
  logic                         in_fire;

  assign in_fire  = in_valid & in_ready;
  assign slice    = data_q[int'(cnt) * 64 +: 64];
  assign acc_next = acc + slice_sum;

  // Sum the elements of the current slice, each sign- or zero-extended.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    slice_sum = '0;
    unique case (esize_q)
      2'd0: for (int i = 0; i < 8; i++)
              slice_sum = slice_sum + {{(ACC_WIDTH-8){signed_q & slice[i*8+7]}}, slice[i*8 +: 8]};
      2'd1: for (int i = 0; i < 4; i++)
              slice_sum = slice_sum + {{(ACC_WIDTH-16){signed_q & slice[i*16+15]}}, slice[i*16 +: 16]};
      2'd2: for (int i = 0; i < 2; i++)
              slice_sum = slice_sum + {{(ACC_WIDTH-32){signed_q & slice[i*32+31]}}, slice[i*32 +: 32]};
      2'd3: slice_sum = {{(ACC_WIDTH-64){signed_q & slice[63]}}, slice};
    endcase
  end

  // The final sum fits a W-bit element when the bits above W are zero
  // (unsigned) or all copies of the W-bit sign bit (signed).
  always_comb begin
    narrow = 1'b0;
    unique case (esize_q)
      2'd0: narrow = signed_q ? ~((&acc_next[ACC_WIDTH-1:7])  | ~(|acc_next[ACC_WIDTH-1:7]))
                              : |acc_next[ACC_WIDTH-1:8];
      2'd1: narrow = signed_q ? ~((&acc_next[ACC_WIDTH-1:15]) | ~(|acc_next[ACC_WIDTH-1:15]))
                              : |acc_next[ACC_WIDTH-1:16];
      2'd2: narrow = signed_q ? ~((&acc_next[ACC_WIDTH-1:31]) | ~(|acc_next[ACC_WIDTH-1:31]))
                              : |acc_next[ACC_WIDTH-1:32];
      2'd3: narrow = signed_q ? ~((&acc_next[ACC_WIDTH-1:63]) | ~(|acc_next[ACC_WIDTH-1:63]))
                              : |acc_next[ACC_WIDTH-1:64];
    endcase
  end

  // Capture the vector payload on the input handshake.
  // NOTE: pure datapath storage, never read before it is loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) data_q <= in_data;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state and outputs use non-blocking assignments so every read sees pre-edge values.
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      esize_q        <= 2'd0;
      signed_q       <= 1'b0;
      lane_flag_q    <= 1'b0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_sum        <= '0;
      out_narrow_ovf <= 1'b0;
      out_lane_flag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            esize_q     <= in_esize;
            signed_q    <= in_signed;
            lane_flag_q <= |(in_ovf | in_udf);
            acc         <= '0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_SLICE) begin
            out_sum        <= acc_next;
            out_narrow_ovf <= narrow;
            out_lane_flag  <= lane_flag_q;
            out_valid      <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_hsum_reduce.sv
// Scoreboard bench for simd_hsum_reduce: a driver pushes expected results
// from an arithmetic reference model, a monitor pops and compares them.
module tb_simd_hsum_reduce;

  localparam int DW = 256;
  localparam int AW = 72;
  localparam int LN = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [LN-1:0] in_ovf;
  logic [LN-1:0] in_udf;
  logic [1:0]    in_esize;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_narrow_ovf;
  logic          out_lane_flag;

  typedef struct {
    logic [AW-1:0] sum;
    logic          narrow;
    logic          lane;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_busy = 1'b0;
  bit   mon_hs   = 1'b0;
  int   n_seen   = 0;

  simd_hsum_reduce #(.SIMD_DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_ovf         (in_ovf),
    .in_udf         (in_udf),
    .in_esize       (in_esize),
    .in_signed      (in_signed),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_narrow_ovf (out_narrow_ovf),
    .out_lane_flag  (out_lane_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: walk every element of the whole vector, interpret it as a
  // plain integer and add it up in wide signed arithmetic.
  function automatic exp_t model(input logic [DW-1:0] d, input logic [LN-1:0] ovf,
                                 input logic [LN-1:0] udf, input logic [1:0] es,
                                 input logic sg, input int acc_cyc);
    exp_t r;
    int w;
    logic signed [127:0] s, e, one;
    w   = 8 << es;
    one = 1;
    s   = 0;
    for (int i = 0; i < DW / w; i++) begin
      e = 0;
      for (int b = 0; b < w; b++) e[b] = d[i*w + b];
      if (sg && e[w-1]) e = e - (one << w);
      s = s + e;
    end
    r.sum = s[AW-1:0];
    if (sg) r.narrow = (s < -(one << (w - 1))) || (s > ((one << (w - 1)) - one));
    else    r.narrow = (s >= (one << w));
    r.lane    = |(ovf | udf);
    r.acc_cyc = acc_cyc;
    return r;
  endfunction

  // Present one vector; while the block is busy, wiggle in_valid with junk.
  task automatic send(input logic [DW-1:0] d, input logic [LN-1:0] ovf, input logic [LN-1:0] udf,
                      input logic [1:0] es, input logic sg);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd_vec();
      in_ovf    = LN'($urandom);
      in_udf    = LN'($urandom);
      in_esize  = 2'($urandom_range(0, 3));
      in_signed = 1'($urandom_range(0, 1));
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_ovf    = ovf;
    in_udf    = udf;
    in_esize  = es;
    in_signed = sg;
    sb.push_back(model(d, ovf, udf, es, sg, cyc + 1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid || mon_busy || mon_hs) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", (g < 300), 1);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compares results, applies backpressure, checks hold stability.
  initial begin : monitor
    int hold;
    logic [AW-1:0] held;
    exp_t e;
    hold = 0;
    held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_hs) begin
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
        mon_hs = 1'b0;
      end
      if (out_valid) begin
        if (!mon_busy) begin
          if (sb.size() == 0) begin
            check("unexpected_out", out_valid, 0);
          end else begin
            e = sb.pop_front();
            check("sum", out_sum, e.sum);
            check("narrow_ovf", out_narrow_ovf, e.narrow);
            check("lane_flag", out_lane_flag, e.lane);
            check("latency", cyc - e.acc_cyc, 4);
          end
          held     = out_sum;
          mon_busy = 1'b1;
          hold     = (n_seen < 6) ? 3 : int'($urandom_range(0, 3));
          n_seen++;
        end else begin
          check("hold_sum", out_sum, held);
          check("hold_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
          hold--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          mon_busy  = 1'b0;
          mon_hs    = 1'b1;
        end
      end else begin
        if (mon_busy) begin
          check("valid_dropped", out_valid, 1);
          mon_busy = 1'b0;
        end
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : main
    logic [DW-1:0] d;
    logic [LN-1:0] ovf;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ovf    = '0;
    in_udf    = '0;
    in_esize  = 2'd0;
    in_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_narrow", out_narrow_ovf, 0);
    check("rst_lane", out_lane_flag, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed vectors.
    send({32{8'h20}}, '0, '0, 2'd0, 1'b0);
    send({32{8'hFE}}, '1, '0, 2'd0, 1'b1);
    send({16{16'h7FFF}}, '0, '0, 2'd1, 1'b0);
    send({4{64'hFFFF_FFFF_FFFF_FC00}}, '0, '0, 2'd3, 1'b1);
    send({4{64'hFFFF_FFFF_FFFF_FFFF}}, '0, '0, 2'd3, 1'b0);
    send({32{8'h7F}}, '0, 32'h0000_0100, 2'd2, 1'b1);

    // Randomised vectors, sometimes restricted to small element values.
    for (int n = 0; n < 40; n++) begin
      d   = rnd_vec();
      if ($urandom_range(0, 2) == 0) d = d & {32{8'h03}};
      ovf = ($urandom_range(0, 1) == 1) ? LN'($urandom) : '0;
      send(d, ovf, ($urandom_range(0, 3) == 0) ? LN'($urandom) : '0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Abort a vector with reset in its second accumulate cycle.
    @(negedge clk);
    check("abort_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = rnd_vec();
    in_ovf    = '1;
    in_esize  = 2'd0;
    in_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_narrow", out_narrow_ovf, 0);
    check("abort_lane", out_lane_flag, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_output", out_valid, 0);
    end
    check("abort_in_ready", in_ready, 1);
    send({32{8'h01}}, '0, '0, 2'd0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
